// File: rtl/pcm_pwm_multi_pkg.sv
// Shared definitions for the multi-channel PCM audio output block:
// output mode encoding, midscale value and frame channel extraction.
package pcm_pkg;

   typedef enum logic {
      MODE_PWM = 1'b0,
      MODE_SD  = 1'b1
   } mode_e;

   function automatic logic [31:0] midscale(input int sw);
      return 32'(1) << (sw - 1);
   endfunction

   // Channel ch of an interleaved frame; callers zero-extend the frame to 256 bits.
   function automatic logic [31:0] frame_slice(input logic [255:0] frame, input int ch,
                                               input int sw);
      return 32'((frame >> (ch * sw)) & ((256'd1 << sw) - 256'd1));
   endfunction

endpackage

// File: rtl/pcm_pwm_multi_if.sv
// CPU-side sound port: one interleaved PCM frame per push, with FIFO-full backpressure.
interface pcm_pwm_multi_if #(
   parameter int CHANNELS = 2,
   parameter int SW       = 10
);
   logic [CHANNELS*SW-1:0] wr_data;
   logic                   wr_req;
   logic                   wr_full;

   modport master (output wr_data, output wr_req, input wr_full);
   modport slave  (input wr_data, input wr_req, output wr_full);
endinterface

// File: rtl/pcm_pwm_multi_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with count-based full/empty flags.
module sync_fifo_fwft #(
   parameter int DW = 20,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          full,
   output logic          empty
);
   localparam int DEPTH = 2 ** AW;
   localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_nxt;
   logic          do_wr, do_rd;

   // Flags are registered, so a write is judged against the pre-pop fill level.
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_comb begin
      count_nxt = count;
      case ({do_wr, do_rd})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == FULL_CNT);
         empty <= (count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/pcm_pwm_multi.sv
// Multi-channel audio output: frame FIFO, programmable sample-rate tick and
// per-channel 1-bit output as carrier PWM or first-order sigma-delta.
module pcm_pwm_multi
   import pcm_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int SW       = 10,
   parameter int FIFO_AW  = 4,
   parameter int RATE_W   = 16
) (
   input  logic                clk,
   input  logic                rst,
   pcm_pwm_multi_if.slave      snd,
   input  logic [RATE_W-1:0]   rate,
   input  logic                mode,
   input  logic                enable,
   output logic [15:0]         underrun_cnt,
   output logic                overflow,
   output logic [CHANNELS-1:0] pwm_out
);
   localparam int FW = CHANNELS * SW;
   localparam logic [SW-1:0] MID = SW'(midscale(SW));

   logic [RATE_W-1:0] rate_cnt;
   logic              tick;
   logic              fifo_full, fifo_empty;
   logic [FW-1:0]     head;
   logic [255:0]      head_wide;
   logic [SW-1:0]     carrier;

   // >= so that a rate lowered below the running count still wraps promptly.
   assign tick      = enable && (rate_cnt >= rate);
   assign head_wide = 256'(head);
   assign snd.wr_full = fifo_full;

   sync_fifo_fwft #(.DW(FW), .AW(FIFO_AW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (snd.wr_req),
      .wr_data (snd.wr_data),
      .rd_en   (tick),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         rate_cnt     <= '0;
         carrier      <= '0;
         underrun_cnt <= '0;
         overflow     <= 1'b0;
      end else begin
         if (!enable) begin
            rate_cnt <= '0;
            carrier  <= '0;
         end else begin
            rate_cnt <= tick ? '0 : rate_cnt + 1'b1;
            carrier  <= carrier + 1'b1;
         end
         if (tick && fifo_empty && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
         if (snd.wr_req && fifo_full)
            overflow <= 1'b1;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [SW-1:0] sample;
      logic [SW-1:0] acc;
      logic [SW:0]   acc_sum;
      logic          out_bit;

      // Only the residue is stored; the carry out of the sum is the output bit.
      assign acc_sum    = {1'b0, acc} + {1'b0, sample};
      assign pwm_out[c] = out_bit;

      always_ff @(posedge clk) begin
         if (!rst || !enable) begin
            sample  <= MID;
            acc     <= '0;
            out_bit <= 1'b0;
         end else begin
            if (tick)
               sample <= fifo_empty ? MID : SW'(frame_slice(head_wide, c, SW));
            acc     <= acc_sum[SW-1:0];
            out_bit <= (mode_e'(mode) == MODE_SD) ? acc_sum[SW] : (carrier < sample);
         end
      end
   end

endmodule

// File: doc/pcm_pwm_multi.md
# pcm_pwm_multi

Parametrised multi-channel audio output block: buffers interleaved PCM frames from the CPU-side sound port in a synchronous frame FIFO. It releases one frame per programmable rate tick and drives one 1-bit output per channel. Each output is either carrier PWM or first-order sigma-delta. Sits between the memory-mapped sound register interface and the board audio pins, replacing the single-channel fixed-width PWM sound controller.

## Interface
- CHANNELS, 2, number of audio channels (1..8)
- SW, 10, sample width in bits (unsigned, midscale = 1<<(SW-1))
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW frames
- RATE_W, 16, width of rate divider

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- wr_data  in  CHANNELS*SW  one frame; channel c in bits [c*SW +: SW]
- wr_req  in  1  push wr_data this cycle
- wr_full  out  1  FIFO full; pushes while high are dropped
- rate  in  RATE_W  tick period minus one, in clk cycles
- mode  in  1  0 = PWM, 1 = sigma-delta
- enable  in  1  output stage run
- underrun_cnt  out  16  saturating count of ticks with FIFO empty
- overflow  out  1  sticky: a push was dropped
- pwm_out  out  CHANNELS  per-channel 1-bit audio

## Operation
- Reset: FIFO empty, wr_full 0, underrun_cnt 0, overflow 0, pwm_out all 0, rate counter 0, carrier 0, accumulators 0, all samples midscale.
- Push: wr_req && !wr_full writes one frame.
  - wr_req && wr_full drops the frame and sets overflow; overflow is cleared only by reset.
  - Full is evaluated before any same-cycle pop, so a push on a full FIFO is dropped even when a tick pops that cycle.
- FIFO is first-word fall-through: head frame is valid whenever not empty.
- Rate counter (RATE_W bits), enable=1:
  - Counts 0..rate; at count==rate it wraps to 0 and asserts tick for that cycle.
  - Tick period is rate+1 cycles; rate=0 gives a tick every cycle.
  - rate changed mid-count takes effect on the compare in the next cycle.
  - If count > rate after a rate decrease, the counter wraps at the next compare (>= rate).
- On tick with FIFO non-empty: pop, and load sample[c] from the head frame.
- On tick with FIFO empty: sample[c] gets midscale; underrun_cnt increments, saturating at 0xFFFF.
  - A push in the same cycle as such a tick does not satisfy it.
- PWM mode:
  - Free-running SW-bit carrier counter, wraps at 2**SW-1 -> 0.
  - pwm_out[c] <= (carrier < sample[c]).
  - sample 0 gives constant 0; sample 2**SW-1 gives high for 2**SW-1 of every 2**SW cycles.
- Sigma-delta mode:
  - acc[c] is SW+1 bits; each cycle acc[c] <= {1'b0, acc[c][SW-1:0]} + sample[c].
  - pwm_out[c] <= acc[c][SW] of the new sum (the carry).
  - Output density = sample/2**SW.
- Mode switch: accumulators and carrier keep running in both modes; the switch takes effect next cycle with no reset of state.
- enable=0:
  - Rate counter, carrier and accumulators are held at 0; no ticks.
  - Samples are forced to midscale; pwm_out is forced to 0.
  - The FIFO still accepts pushes.
- Width rule: all comparisons are unsigned. Sample registers are exactly SW bits (no truncation to narrower register).

## Timing
- Push to not-empty: 1 cycle; a push at cycle n can be popped by a tick at n+1.
- Tick at cycle n: sample loaded at edge n+1; first pwm_out bit reflecting it appears after edge n+2.
- wr_full and underrun_cnt update one edge after their cause; all outputs are registered.
- Reset mid-operation: the next edge restores every reset value; in-flight FIFO contents are discarded.

## Structure
- Shared package pcm_pkg holds the midscale function, the mode encoding (MODE_PWM=0, MODE_SD=1) and the frame-slice helper.
- Sub-module sync_fifo_fwft (params DW, AW):
  - Single clock, FWFT, count-based full/empty.
  - Write-when-full is ignored internally; overflow flag logic stays in the parent.
- Per-channel sample/accumulator/output logic is a generate loop in the parent, not a separate module.

## Test plan
- Reset, enable=1, rate=3, mode=0, no pushes:
  - samples stay 512 (SW=10); pwm_out duty is 512/1024 on both channels.
  - underrun_cnt increments every 4 cycles.
- Push 16 frames without ticks (enable=0):
  - wr_full rises after the 16th push.
  - A 17th push sets overflow, and FIFO count stays 16.
- rate=0, enable=1, FIFO holding frames {ch0=0,ch1=1023} then {ch0=256,ch1=768}:
  - samples load on consecutive cycles, then drop to midscale.
  - underrun_cnt starts counting from the third tick.
- mode=1, constant sample 256 (SW=10): exactly 256 ones per 1024-cycle window on pwm_out.
- Tick coincident with a push into an empty FIFO:
  - that tick underruns, loads midscale and increments underrun_cnt.
  - the next tick pops the pushed frame.
- Assert rst low mid-stream with 5 frames queued: next cycle FIFO empty, overflow 0, underrun_cnt 0, pwm_out 0.
